serial_sub: RTL
===============

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide port start  input  1  request: capture a, b and begin subtraction.
REQ-005 SHALL provide port a  input  WIDTH  minuend, unsigned.
REQ-006 SHALL provide port b  input  WIDTH  subtrahend, unsigned.
REQ-007 SHALL provide port busy  output  1  high while bits are being processed.
REQ-008 SHALL provide port done  output  1  one-cycle pulse, result valid.
REQ-009 SHALL provide port diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 SHALL provide port brr  output  1  final borrow out (1 when a<b).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; only transitions IDLE->SHIFT, SHIFT->DONE, DONE->IDLE.
REQ-012 SHALL, in IDLE with start=1 at edge E, load a and b into shift registers, clear internal borrow and bit counter, enter SHIFT.
REQ-013 SHALL process one bit per SHIFT cycle, LSB first: d = ai^bi^br; br_next = (~ai & bi) | (~(ai^bi) & br).
REQ-014 SHALL shift each d into the result register from the MSB end so the register holds LSB-aligned diff after WIDTH bits.
REQ-015 SHALL spend exactly WIDTH cycles in SHIFT (edges E+1..E+WIDTH), then enter DONE.
REQ-016 SHALL assert done for exactly the one cycle in DONE (after edge E+WIDTH), then return to IDLE at edge E+WIDTH+1.
REQ-017 SHALL assert busy exactly while in SHIFT; busy and done never high together.
REQ-018 SHALL update diff and brr only at the SHIFT->DONE transition; both hold stable until the next completed operation.
REQ-019 SHALL ignore start while in SHIFT or DONE; a, b changes after capture have no effect.
REQ-020 SHALL accept start in the IDLE cycle directly following DONE (back-to-back throughput WIDTH+2 cycles).
REQ-021 SHALL keep partial results internal; diff/brr never show intermediate bits.

Reset
REQ-022 SHALL, on rst_n=0, immediately force state IDLE, busy=0, done=0, diff=0, brr=0, counter and borrow 0.
REQ-023 SHALL abort any operation in progress on reset with no done pulse; first start after rst_n release begins a clean operation.

Configuration
REQ-024 SHALL support macro SERIAL_SUB_SAT_EN: when defined, a final borrow of 1 forces diff to all-zeros at DONE (unsigned floor saturation), brr still 1.
REQ-025 SHALL, without SERIAL_SUB_SAT_EN, output the wrapped modulo-2^WIDTH result; latency and handshake identical in both builds.

Verification
REQ-026 SHALL check WIDTH=8, a=0x05 b=0x03 start -> busy 8 cycles, done pulse, diff=0x02 brr=0.
REQ-027 SHALL check WIDTH=8, a=0x03 b=0x05 -> diff=0xFE brr=1; with SERIAL_SUB_SAT_EN diff=0x00 brr=1.
REQ-028 SHALL check WIDTH=8, a=0x00 b=0xFF -> diff=0x01 brr=1; a=0xFF b=0xFF -> diff=0x00 brr=0.
REQ-029 SHALL check start re-pulsed mid-SHIFT with new operands -> ignored, original result reported, single done.
REQ-030 SHALL check rst_n low at SHIFT cycle 4 -> outputs zero at once, no done; next start a=0x10 b=0x01 -> diff=0x0F.
REQ-031 SHALL check back-to-back: start in cycle after done -> second result after WIDTH+2 cycles; WIDTH=4 exhaustive 256 pairs vs a-b.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first, result after WIDTH cycles.
// Define SERIAL_SUB_SAT_EN to clamp a negative result (final borrow) to zero.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             brr
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             brr_q, brr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             aBit, bBit, dBit, brNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            brr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            brr_q   <= brr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        brr_d   = brr_q;
        cnt_d   = cnt_q;

        aBit   = aSh_q[0];
        bBit   = bSh_q[0];
        dBit   = aBit ^ bBit ^ br_q;
        brNext = (~aBit & bBit) | (~(aBit ^ bBit) & br_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    aSh_d   = a;
                    bSh_d   = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                aSh_d = aSh_q >> 1;
                bSh_d = bSh_q >> 1;
                res_d = {dBit, res_q[WIDTH-1:1]};
                br_d  = brNext;
                cnt_d = cnt_q + CW'(1);
                // Visible outputs change only once the last bit has been folded in.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    diff_d  = {dBit, res_q[WIDTH-1:1]};
                    brr_d   = brNext;
`ifdef SERIAL_SUB_SAT_EN
                    if (brNext) begin
                        diff_d = '0;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign brr  = brr_q;

endmodule
